// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: Set-2 scan-code constants and the deframer state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_ECHO       = 8'hEE;
  localparam logic [7:0] PS2_KEY_SPACE  = 8'h29;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Keyboard housekeeping replies that carry no key information on their own.
  function automatic logic ps2_is_reply(input logic [7:0] code);
    return (code == PS2_BAT_OK) || (code == PS2_ACK) ||
           (code == PS2_RESEND) || (code == PS2_ECHO);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 pins, glitch-filters the keyboard clock and emits a one-cycle
// strobe with the sampled data bit on every filtered rising edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic strobe_o,
  output logic bit_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          strobe_q;
  logic          bit_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      strobe_q   <= 1'b0;
      // Any return to the current filtered level restarts the hold count.
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt_q <= clk_sync_q[1];
        cnt_q  <= '0;
        if (clk_sync_q[1]) begin
          strobe_q <= 1'b1;
          bit_q    <= dat_sync_q[1];
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign strobe_o = strobe_q;
  assign bit_o    = bit_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames with parity/framing/timeout checks and
// decodes Set-2 make/break/extended sequences into key events and a SPACE held level.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int          FILTER_LEN     = 8,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SPACE_CODE     = PS2_KEY_SPACE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_err_o,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_make_o,
  output logic       key_break_o,
  output logic       space_down_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic strobe;
  logic sbit;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .strobe_o  (strobe),
    .bit_o     (sbit)
  );

  ps2_state_e    state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (strobe) begin
        to_cnt_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!sbit) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {sbit, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= sbit;
            state_q <= STOP;
          end
          STOP: begin
            // Odd parity: data ones plus the parity bit must be odd.
            if (sbit && (^shift_q ^ par_q)) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_cnt_q == TO_MAX) begin
          rx_err_q <= 1'b1;
          state_q  <= IDLE;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  logic       ext_q;
  logic       brk_q;
  logic [7:0] key_code_q;
  logic       key_ext_q;
  logic       key_make_q;
  logic       key_break_q;
  logic       space_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_make_q  <= 1'b0;
      key_break_q <= 1'b0;
      space_q     <= 1'b0;
    end else begin
      key_make_q  <= 1'b0;
      key_break_q <= 1'b0;
      if (rx_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_data_q == PS2_PREFIX_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_data_q == PS2_PREFIX_BRK) begin
          brk_q <= 1'b1;
        end else if (!(ps2_is_reply(rx_data_q) && !ext_q && !brk_q)) begin
          key_code_q  <= rx_data_q;
          key_ext_q   <= ext_q;
          key_make_q  <= !brk_q;
          key_break_q <= brk_q;
          ext_q       <= 1'b0;
          brk_q       <= 1'b0;
          // Only the non-extended code counts; E0 29 is a different key.
          if ((rx_data_q == SPACE_CODE) && !ext_q) space_q <= !brk_q;
        end
      end
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_err_o     = rx_err_q;
  assign key_code_o   = key_code_q;
  assign key_ext_o    = key_ext_q;
  assign key_make_o   = key_make_q;
  assign key_break_o  = key_break_q;
  assign space_down_o = space_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are driven on the pins while a behavioural
// model queues the expected bytes, errors and key events for an independent monitor.
module tb_ps2_keyboard_rx;

  localparam int FILT = 16;
  localparam int TOUT = 2000;
  localparam int HP   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_break;
  logic       space_down;

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TOUT),
    .SPACE_CODE     (8'h29)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_err_o     (rx_err),
    .key_code_o   (key_code),
    .key_ext_o    (key_ext),
    .key_make_o   (key_make),
    .key_break_o  (key_break),
    .space_down_o (space_down)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } rx_exp_t;

  typedef struct {
    bit         brk;
    logic [7:0] code;
    bit         ext;
    bit         space;
  } key_exp_t;

  rx_exp_t  rx_q[$];
  key_exp_t key_q[$];

  bit         m_ext;
  bit         m_brk;
  bit         m_space;
  logic [7:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the protocol rules applied to whole bytes.
  function automatic void model_good(input logic [7:0] b);
    rx_q.push_back('{is_err: 1'b0, data: b});
    m_last = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) begin
    end else begin
      if (b == 8'h29 && !m_ext) m_space = !m_brk;
      key_q.push_back('{brk: m_brk, code: b, ext: m_ext, space: m_space});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_bad();
    rx_q.push_back('{is_err: 1'b1, data: m_last});
    m_ext = 1'b0;
    m_brk = 1'b0;
  endfunction

  function automatic void model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_space = 1'b0;
    m_last = 8'h00;
    rx_q.delete();
    key_q.delete();
  endfunction

  // Drives the first nbits of a frame; glitch_bit gets a short low pulse after its strobe.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        repeat (22) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HP - 32) @(posedge clk);
      end else begin
        repeat (HP) @(posedge clk);
      end
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input int glitch_bit);
    model_good(b);
    send_frame(b, 1'b0, 1'b0, 11, glitch_bit);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("space_level", {31'd0, space_down}, {31'd0, m_space});
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_bad();
    send_frame(b, bad_par, bad_stop, 11, -1);
    repeat (60) @(posedge clk);
  endtask

  rx_exp_t  mon_rx;
  key_exp_t mon_key;
  bit       prev_valid = 1'b0;
  bit       prev_err = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid || rx_err) begin
        check("rx_pulse_width", {30'd0, prev_valid & rx_valid, prev_err & rx_err}, 32'd0);
        check("rx_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=valid%0b/err%0b required=none", rx_valid, rx_err);
        end else begin
          mon_rx = rx_q.pop_front();
          check("rx_kind_err", {31'd0, rx_err}, {31'd0, mon_rx.is_err});
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_rx.data});
          $display("rx %s data=%02h", rx_err ? "error" : "byte ", rx_data);
        end
      end
      if (key_make || key_break) begin
        if (key_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_unexpected actual=make%0b/break%0b code=%02h required=none",
                   key_make, key_break, key_code);
        end else begin
          mon_key = key_q.pop_front();
          check("key_make", {31'd0, key_make}, {31'd0, !mon_key.brk});
          check("key_break", {31'd0, key_break}, {31'd0, mon_key.brk});
          check("key_code", {24'd0, key_code}, {24'd0, mon_key.code});
          check("key_ext", {31'd0, key_ext}, {31'd0, mon_key.ext});
          check("space_down", {31'd0, space_down}, {31'd0, mon_key.space});
          $display("key %s code=%02h ext=%0b space=%0b", key_break ? "break" : "make ",
                   key_code, key_ext, space_down);
        end
      end
    end
    prev_valid = rx_valid;
    prev_err = rx_err;
  end

  initial begin
    repeat (200000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    int lat;
    logic [7:0] b;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {10'd0, rx_data, rx_valid, rx_err, key_code, key_ext, key_make,
                            key_break, space_down}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Reset during a partial frame, then a clean SPACE press.
    send_good(8'h29, -1);
    send_frame(8'h29, 1'b0, 1'b0, 5, -1);
    #3 rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {10'd0, rx_data, rx_valid, rx_err, key_code, key_ext,
                                     key_make, key_break, space_down}, 32'd0);
    model_reset();
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    send_good(8'h29, -1);

    // Release, then extended make/break of the same code.
    send_good(8'hF0, -1);
    send_good(8'h29, -1);
    send_good(8'hE0, -1);
    send_good(8'h29, -1);
    send_good(8'hE0, -1);
    send_good(8'hF0, -1);
    send_good(8'h29, -1);

    // Parity and stop errors; the pending break prefix must be dropped.
    send_bad(8'h1C, 1'b1, 1'b0);
    send_good(8'h29, -1);
    send_good(8'hF0, -1);
    send_bad(8'h29, 1'b0, 1'b1);

    // Truncated frame followed by silence.
    model_bad();
    send_frame(8'h55, 1'b0, 1'b0, 4, -1);
    n = 0;
    while (!rx_err && n < 3 * TOUT) begin
      @(negedge clk);
      n++;
    end
    lat = HP + n;
    check("timeout_latency_in_window", {31'd0, (lat >= TOUT) && (lat <= TOUT + FILT + 10)}, 32'd1);
    $display("timeout after %0d cycles from last clock rise", lat);
    repeat (3 * TOUT - n) @(posedge clk);
    send_good(8'h29, -1);

    // Short clock glitches while idle and inside a high phase.
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (80) @(posedge clk);
    end
    send_good(8'hF0, 4);
    send_good(8'h29, 7);

    // Randomised traffic.
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2, 3: b = 8'h29;
        4: b = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) send_bad(b, 1'b1, 1'b0);
      else if ($urandom_range(0, 7) == 0) send_bad(b, 1'b0, 1'b1);
      else send_good(b, -1);
    end

    repeat (100) @(posedge clk);
    check("rx_queue_drained", rx_q.size(), 32'd0);
    check("key_queue_drained", key_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
